// File: rtl/rgb_pkg.sv
// Constants and pixel type shared by the RGB test-pattern generator and checker.
// Both ends derive the ramp from these seeds and steps so they stay in lock-step.
package rgb_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam logic [7:0] DEF_SEED_R = 8'd0;
  localparam logic [7:0] DEF_SEED_G = 8'd85;
  localparam logic [7:0] DEF_SEED_B = 8'd170;

  localparam logic [7:0] STEP_R = 8'd1;
  localparam logic [7:0] STEP_G = 8'd2;
  localparam logic [7:0] STEP_B = 8'd3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // One ramp step; 8-bit adds give the modulo-256 wrap for free.
  function automatic rgb_t rgb_advance(input rgb_t p);
    rgb_t n;
    n.r = p.r + STEP_R;
    n.g = p.g + STEP_G;
    n.b = p.b + STEP_B;
    return n;
  endfunction

endpackage

// File: rtl/rgb_expected_gen.sv
// Three modulo-256 ramp counters producing the expected pixel value.
// load takes priority over advance.
module rgb_expected_gen
  import rgb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  rgb_t load_value,
  input  logic advance,
  output rgb_t expected
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected <= '0;
    end else if (load) begin
      expected <= load_value;
    end else if (advance) begin
      expected <= rgb_advance(expected);
    end
  end

endmodule

// File: rtl/rgb_pattern_checker.sv
// Sink-side checker for the RGB ramp pattern: tracks raster position, compares
// each accepted pixel with the regenerated ramp and reports per-frame statistics.
module rgb_pattern_checker
  import rgb_pkg::*;
#(
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int SEED_R        = int'(DEF_SEED_R),
  parameter int SEED_G        = int'(DEF_SEED_G),
  parameter int SEED_B        = int'(DEF_SEED_B),
  parameter bit LOCK_ON_FIRST = 1'b0,
  parameter int ERR_W         = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        arm,
  input  logic                        pixel_valid,
  input  logic [23:0]                 pixel_rgb,
  output logic                        busy,
  output logic                        pixel_err,
  output logic                        frame_done,
  output logic                        frame_ok,
  output logic [ERR_W-1:0]            err_count,
  output logic [$clog2(H_ACTIVE)-1:0] first_err_x,
  output logic [$clog2(V_ACTIVE)-1:0] first_err_y,
  output logic [15:0]                 frame_count
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
  localparam rgb_t SEED = '{r: 8'(SEED_R), g: 8'(SEED_G), b: 8'(SEED_B)};

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  state_t state, state_next;

  logic [XW-1:0]    x, shadow_x, fx_final;
  logic [YW-1:0]    y, shadow_y, fy_final;
  logic [ERR_W-1:0] run_err, err_total;
  rgb_t             pixel, expected, load_value;
  logic             accept, mismatch, last_pixel, load, advance;

  assign pixel      = rgb_t'(pixel_rgb);
  assign busy       = (state != IDLE);
  assign accept     = pixel_valid && !arm && (state != IDLE);
  assign mismatch   = accept && (state == CHECK) && (pixel != expected);
  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

  // In SYNC the received pixel becomes the reference, so the next one is pixel + step.
  assign load       = arm || (accept && state == SYNC);
  assign load_value = arm ? SEED : rgb_advance(pixel);
  assign advance    = accept && (state == CHECK);

  assign err_total = (mismatch && run_err != '1) ? run_err + ERR_W'(1) : run_err;
  assign fx_final  = (run_err != '0) ? shadow_x : (mismatch ? x : '0);
  assign fy_final  = (run_err != '0) ? shadow_y : (mismatch ? y : '0);

  rgb_expected_gen u_expected_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_value(load_value),
    .advance   (advance),
    .expected  (expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (arm) begin
      state_next = LOCK_ON_FIRST ? SYNC : CHECK;
    end else if (state == SYNC && pixel_valid) begin
      state_next = CHECK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      shadow_x    <= '0;
      shadow_y    <= '0;
      run_err     <= '0;
      pixel_err   <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_count   <= '0;
      first_err_x <= '0;
      first_err_y <= '0;
      frame_count <= '0;
    end else begin
      pixel_err  <= mismatch;
      frame_done <= 1'b0;
      if (arm) begin
        x           <= '0;
        y           <= '0;
        run_err     <= '0;
        frame_ok    <= 1'b0;
        err_count   <= '0;
        first_err_x <= '0;
        first_err_y <= '0;
        frame_count <= '0;
      end else if (accept) begin
        if (last_pixel) begin
          // Publish the frame and start the next one at (0,0) on the same edge.
          x           <= '0;
          y           <= '0;
          run_err     <= '0;
          frame_done  <= 1'b1;
          frame_ok    <= (err_total == '0);
          err_count   <= err_total;
          first_err_x <= fx_final;
          first_err_y <= fy_final;
          frame_count <= frame_count + 16'd1;
        end else begin
          run_err <= err_total;
          if (mismatch && run_err == '0) begin
            shadow_x <= x;
            shadow_y <= y;
          end
          if (x == X_LAST) begin
            x <= '0;
            y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_pattern_checker.sv
// Randomised bench for rgb_pattern_checker on a 4x2 raster; expected results come
// from an index-based ramp model (pixel n = seed + n*step) with per-frame bookkeeping.
module tb_rgb_pattern_checker;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;
  localparam logic [23:0] SEED = 24'h0055AA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        arm_lock = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [23:0] pixel_rgb = '0;

  logic        busy, pixel_err, frame_done, frame_ok;
  logic [15:0] err_count, frame_count;
  logic [1:0]  first_err_x;
  logic [0:0]  first_err_y;

  logic        lk_busy, lk_pixel_err, lk_frame_done, lk_frame_ok;
  logic [15:0] lk_err_count, lk_frame_count;
  logic [1:0]  lk_first_err_x;
  logic [0:0]  lk_first_err_y;

  always #5 clk = ~clk;

  rgb_pattern_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_ON_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb),
    .busy(busy), .pixel_err(pixel_err), .frame_done(frame_done), .frame_ok(frame_ok),
    .err_count(err_count), .first_err_x(first_err_x), .first_err_y(first_err_y),
    .frame_count(frame_count)
  );

  rgb_pattern_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_ON_FIRST(1'b1)) dut_lock (
    .clk(clk), .rst_n(rst_n), .arm(arm_lock), .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb),
    .busy(lk_busy), .pixel_err(lk_pixel_err), .frame_done(lk_frame_done), .frame_ok(lk_frame_ok),
    .err_count(lk_err_count), .first_err_x(lk_first_err_x), .first_err_y(lk_first_err_y),
    .frame_count(lk_frame_count)
  );

  // Observed vector: {pixel_err, frame_done, frame_ok, err_count, fx, fy, frame_count, busy}
  wire [38:0] obs    = {pixel_err, frame_done, frame_ok, err_count, first_err_x, first_err_y,
                        frame_count, busy};
  wire [38:0] lk_obs = {lk_pixel_err, lk_frame_done, lk_frame_ok, lk_err_count, lk_first_err_x,
                        lk_first_err_y, lk_frame_count, lk_busy};

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  logic [23:0] m_seed;
  int m_n, m_pos, m_errs, m_fx, m_fy, m_frames;
  logic p_err, p_done, p_ok;
  int p_cnt, p_fx, p_fy;

  function automatic logic [23:0] exp_pix(input logic [23:0] seed, input int n);
    logic [7:0] r, g, b;
    r = seed[23:16] + 8'(n);
    g = seed[15:8] + 8'(2 * n);
    b = seed[7:0] + 8'(3 * n);
    return {r, g, b};
  endfunction

  function automatic logic [38:0] exp_vec(input logic exp_busy);
    return {p_err, p_done, p_ok, 16'(p_cnt), 2'(p_fx), 1'(p_fy), 16'(m_frames), exp_busy};
  endfunction

  task automatic model_arm(input logic [23:0] seed);
    m_seed = seed; m_n = 0; m_pos = 0; m_errs = 0; m_frames = 0; m_fx = 0; m_fy = 0;
    p_err = 0; p_done = 0; p_ok = 0; p_cnt = 0; p_fx = 0; p_fy = 0;
  endtask

  task automatic model_pixel(input logic [23:0] pix);
    p_err = (pix != exp_pix(m_seed, m_n));
    m_n++;
    if (p_err) begin
      if (m_errs == 0) begin
        m_fx = m_pos % H;
        m_fy = m_pos / H;
      end
      m_errs++;
    end
    m_pos++;
    p_done = 0;
    if (m_pos == N) begin
      p_done = 1;
      p_cnt  = m_errs;
      p_ok   = (m_errs == 0);
      p_fx   = (m_errs != 0) ? m_fx : 0;
      p_fy   = (m_errs != 0) ? m_fy : 0;
      m_frames++;
      m_pos  = 0;
      m_errs = 0;
    end
  endtask

  // Drive one cycle; outputs are sampled 1 time unit after the edge on return.
  task automatic push(input logic v, input logic [23:0] pix);
    pixel_valid = v;
    pixel_rgb   = pix;
    if (v) model_pixel(pix);
    else begin p_err = 0; p_done = 0; end
    @(posedge clk); #1;
    pixel_valid = 1'b0;
  endtask

  task automatic pulse_arm(input logic lock, input logic with_pix);
    if (lock) arm_lock = 1'b1; else arm = 1'b1;
    pixel_valid = with_pix;
    pixel_rgb   = 24'($urandom);
    @(posedge clk); #1;
    arm = 1'b0; arm_lock = 1'b0; pixel_valid = 1'b0;
    model_arm(SEED);
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if (obs !== '0 || lk_obs !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs got=%h/%h exp=0", obs, lk_obs);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (obs !== '0) begin
      mismatched++;
      $display("FAIL reset_idle got=%h exp=0", obs);
    end
  endtask

  task automatic test_clean();
    pulse_arm(1'b0, 1'b1);
    compared++;
    if (obs !== exp_vec(1'b1)) begin
      mismatched++;
      $display("FAIL clean_arm got=%h exp=%h", obs, exp_vec(1'b1));
    end
    for (int i = 0; i < N; i++) begin
      push(1'b1, exp_pix(SEED, i));
      compared++;
      if (obs !== exp_vec(1'b1)) begin
        mismatched++;
        $display("FAIL clean px=%0d got=%h exp=%h", i, obs, exp_vec(1'b1));
      end
    end
    push(1'b0, '0);
    compared++;
    if (obs !== exp_vec(1'b1)) begin
      mismatched++;
      $display("FAIL clean_hold got=%h exp=%h", obs, exp_vec(1'b1));
    end
  endtask

  task automatic test_single_error();
    pulse_arm(1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      push(1'b1, (i == 5) ? 24'h000000 : exp_pix(SEED, i));
      compared++;
      if (obs !== exp_vec(1'b1)) begin
        mismatched++;
        $display("FAIL single_err px=%0d got=%h exp=%h", i, obs, exp_vec(1'b1));
      end
    end
  endtask

  task automatic test_wrap();
    pulse_arm(1'b0, 1'b0);
    for (int i = 0; i < 32 * N; i++) begin
      push(1'b1, exp_pix(SEED, i));
      compared++;
      if (obs !== exp_vec(1'b1)) begin
        mismatched++;
        $display("FAIL wrap px=%0d got=%h exp=%h", i, obs, exp_vec(1'b1));
      end
    end
  endtask

  task automatic test_gaps_random();
    logic [23:0] pix;
    pulse_arm(1'b0, 1'b0);
    for (int i = 0; i < 4 * N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        push(1'b0, 24'($urandom));
        compared++;
        if (obs !== exp_vec(1'b1)) begin
          mismatched++;
          $display("FAIL gap px=%0d got=%h exp=%h", i, obs, exp_vec(1'b1));
        end
      end
      pix = exp_pix(SEED, i);
      if ($urandom_range(0, 5) == 0) pix = pix ^ (24'($urandom) | 24'h000100);
      push(1'b1, pix);
      compared++;
      if (obs !== exp_vec(1'b1)) begin
        mismatched++;
        $display("FAIL gap_rand px=%0d got=%h exp=%h", i, obs, exp_vec(1'b1));
      end
    end
  endtask

  task automatic test_restart();
    pulse_arm(1'b0, 1'b0);
    for (int i = 0; i < N + 3; i++) push(1'b1, (i == 1) ? 24'h123456 : exp_pix(SEED, i));
    // Arm while busy with a pixel present: the pixel is dropped and results clear.
    pulse_arm(1'b0, 1'b1);
    compared++;
    if (obs !== exp_vec(1'b1)) begin
      mismatched++;
      $display("FAIL restart_arm got=%h exp=%h", obs, exp_vec(1'b1));
    end
    for (int i = 0; i < N - 1; i++) push(1'b1, exp_pix(SEED, i));
    // Arm in the would-be last-pixel cycle: no frame_done.
    pulse_arm(1'b0, 1'b1);
    compared++;
    if (obs !== exp_vec(1'b1)) begin
      mismatched++;
      $display("FAIL restart_last got=%h exp=%h", obs, exp_vec(1'b1));
    end
    for (int i = 0; i < N; i++) begin
      push(1'b1, exp_pix(SEED, i));
      compared++;
      if (obs !== exp_vec(1'b1)) begin
        mismatched++;
        $display("FAIL restart px=%0d got=%h exp=%h", i, obs, exp_vec(1'b1));
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_arm(1'b0, 1'b0);
    for (int i = 0; i < N + 3; i++) push(1'b1, (i == 2) ? 24'hFFFFFF : exp_pix(SEED, i));
    compared++;
    if (obs !== exp_vec(1'b1)) begin
      mismatched++;
      $display("FAIL areset_pre got=%h exp=%h", obs, exp_vec(1'b1));
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (obs !== '0) begin
      mismatched++;
      $display("FAIL areset_now got=%h exp=0", obs);
    end
    #2 rst_n = 1'b1;
    model_arm(SEED);
    @(posedge clk); #1;
    for (int i = 0; i < N + 2; i++) begin
      pixel_valid = 1'b1;
      pixel_rgb   = exp_pix(SEED, i);
      @(posedge clk); #1;
      pixel_valid = 1'b0;
      compared++;
      if (obs !== '0) begin
        mismatched++;
        $display("FAIL areset_ignore px=%0d got=%h exp=0", i, obs);
      end
    end
  endtask

  task automatic test_lock();
    pulse_arm(1'b1, 1'b0);
    m_seed = 24'h102030;
    for (int i = 0; i < 2 * N; i++) begin
      push(1'b1, (i == N + 2) ? 24'h0F0F0F : exp_pix(m_seed, i));
      compared++;
      if (lk_obs !== exp_vec(1'b1) || obs !== '0) begin
        mismatched++;
        $display("FAIL lock px=%0d got=%h exp=%h main=%h", i, lk_obs, exp_vec(1'b1), obs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_wrap();
    test_gaps_random();
    test_restart();
    test_async_reset();
    test_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_pattern_checker.md
Name: rgb_pattern_checker

Overview:
Receive-side partner of the RGB test-pattern generator. It consumes the 24-bit pixel stream, tracks raster position and regenerates the expected R/G/B ramp values. It compares every accepted pixel against the expected value and reports per-frame error statistics. It sits at the sink end of the pixel path in simulation and FPGA self-test, so it can confirm that the generator and any intervening pipeline delivered an uncorrupted frame.

Parameters:
H_ACTIVE, 640, pixels per line
V_ACTIVE, 480, lines per frame
SEED_R, 0, expected red value of the first pixel after arm
SEED_G, 85, expected green value of the first pixel after arm
SEED_B, 170, expected blue value of the first pixel after arm
LOCK_ON_FIRST, 0, 1 = take the seed from the first received pixel instead of SEED_*
ERR_W, 16, width of the error counter

Ports:
clk  input  1  clock; all logic is on the rising edge
rst_n  input  1  asynchronous active-low reset
arm  input  1  single-cycle pulse; starts or restarts checking
pixel_valid  input  1  pixel_rgb carries a pixel this cycle
pixel_rgb  input  24  {R[23:16], G[15:8], B[7:0]}
busy  output  1  checker is in SYNC or CHECK
pixel_err  output  1  registered mismatch flag for the previous accepted pixel
frame_done  output  1  one-cycle pulse after the last pixel of a frame
frame_ok  output  1  latched at frame_done: the frame had zero errors
err_count  output  ERR_W  errors in the last completed frame, saturating
first_err_x  output  clog2(H_ACTIVE)  x position of the first error in the last frame
first_err_y  output  clog2(V_ACTIVE)  y position of the first error in the last frame
frame_count  output  16  completed frames since arm, wraps at 2^16

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0. Internal x, y, expected counters and running error count are cleared.
- States:
  - IDLE: pixels are ignored. arm goes to CHECK, or to SYNC if LOCK_ON_FIRST=1.
  - SYNC: the first valid pixel loads the expected counters with its value plus one step. It counts as position (0,0) with no error. Then go to CHECK.
  - CHECK: every valid pixel is compared to the expected value.
- On arm: x=y=0, running error count=0, frame_count=0. Expected counters are set to SEED_R/G/B. A pixel presented in the arm cycle is ignored.
- arm while busy: abort the current frame with no frame_done. Restart as above. arm has priority over pixel_valid.
- Expected model: each accepted pixel advances R by 1, G by 2 and B by 3, all modulo 256 (8-bit wrap, no saturation).
  - The counters are not reset per frame, so frame 2 continues the ramp.
  - pixel_valid low holds all state (gaps are legal).
- Comparison: all 24 bits must match.
  - pixel_err is asserted on the cycle after a mismatching accepted pixel and is 0 otherwise.
  - The running error count saturates at 2^ERR_W-1.
  - The first mismatch in a frame captures x,y into shadow registers.
- Raster: x increments per accepted pixel. At x=H_ACTIVE-1, x wraps to 0 and y increments. At y=V_ACTIVE-1 and x=H_ACTIVE-1 the frame ends.
- Frame end (cycle after the last pixel):
  - frame_done=1 for one cycle.
  - err_count, frame_ok and first_err_x/y update on that same cycle. If there were no errors, first_err_x/y = 0.
  - frame_count increments.
  - The running counters clear for the next frame. A pixel accepted in the frame_done cycle belongs to the new frame at (0,0).
- Outputs err_count, frame_ok and first_err_* hold until the next frame end, arm or reset.

Decomposition:
- Shared package rgb_pkg:
  - default H_ACTIVE/V_ACTIVE
  - seed constants 0/85/170
  - step constants 1/2/3
  - a packed rgb pixel typedef {r,g,b} of 8 bits each
- The generator and the checker both use the seed and step constants from rgb_pkg.
- One sub-module, rgb_expected_gen: the three modulo-256 ramp counters with load (seed) and advance inputs. It is reused as a golden model in benches.

Test Plan:
- Use H_ACTIVE=4, V_ACTIVE=2, SEED defaults.
- Clean frame: arm, then 8 valid pixels 0x0055AA, 0x0157AD, 0x0259B0, … -> frame_done after pixel 8, frame_ok=1, err_count=0, frame_count=1, pixel_err never high.
- Single error: corrupt pixel 5 (x=1,y=1) to 0x000000 -> pixel_err high the next cycle; at frame end err_count=1, frame_ok=0, first_err_x=1, first_err_y=1.
- Wrap: stream 256 correct pixels across 32 frames -> pixel 86 green = 0x01 is accepted; pixel 256 = 0x0055AA is accepted; frame_count=32 and all frame_ok.
- Gaps and restart: deassert pixel_valid randomly mid-frame -> same results as the gap-free case. Pulse arm after 3 pixels -> no frame_done, and the next 8 pixels starting 0x0055AA form a clean frame.
- LOCK_ON_FIRST=1: first pixel 0x102030, then 0x112233, … -> no errors, frame_ok=1.
- Async reset: drop rst_n for half a cycle mid-frame -> outputs 0 immediately, state IDLE, pixels ignored until arm.
